if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, entry count; legal values 2 and 4 only.
REQ-002 SHALL have parameter NOP_INST, default 32'h0340_0000, LA32R nop driven on out_inst when empty.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  fetch presents a pc/inst pair.
REQ-006 SHALL have port in_pc  input  32  pc of fetched instruction.
REQ-007 SHALL have port in_inst  input  32  fetched instruction word.
REQ-008 SHALL have port in_ready  output  1  buffer can accept a pair this cycle.
REQ-009 SHALL have port flush  input  1  branch redirect; discard all buffered and incoming pairs.
REQ-010 SHALL have port out_valid  output  1  head entry valid toward decode.
REQ-011 SHALL have port out_pc  output  32  pc of head entry.
REQ-012 SHALL have port out_inst  output  32  instruction of head entry.
REQ-013 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL implement an in-order circular FIFO of DEPTH entries, each {pc[31:0], inst[31:0]}, with read/write pointers wrapping modulo DEPTH.
REQ-016 SHALL define push = in_valid & in_ready & ~flush, pop = out_valid & out_ready & ~flush.
REQ-017 SHALL drive in_ready = (count < DEPTH), from registered state only; no combinational path from out_ready to in_ready.
REQ-018 SHALL drive out_valid = (count != 0), from registered state only.
REQ-019 SHALL drive out_pc/out_inst from the head entry when out_valid=1; 32'h0 and NOP_INST when out_valid=0.
REQ-020 SHALL make a pushed pair visible on out_* no earlier than the next cycle; no same-cycle bypass from in_* to out_*.
REQ-021 SHALL on push only: write entry at write pointer, advance write pointer, count+1.
REQ-022 SHALL on pop only: advance read pointer, count-1.
REQ-023 SHALL on simultaneous push and pop (count between 1 and DEPTH-1): write and read, count unchanged.
REQ-024 SHALL when full (count=DEPTH) hold in_ready=0 even if out_ready=1; a pop that cycle frees one entry for the next cycle.
REQ-025 SHALL when empty ignore out_ready; no pointer or count change.
REQ-026 SHALL on flush=1: next cycle count=0, pointers=0, out_valid=0; same-cycle in_valid pair dropped; same-cycle out_ready does not count as consumption.
REQ-027 SHALL accept a new push in the cycle after flush (in_ready=1).
REQ-028 SHALL never overwrite an unpopped entry and never present a stale entry after flush.

Reset
REQ-029 SHALL on rst=1 at posedge clear count, read pointer and write pointer to 0, giving out_valid=0, in_ready=1, out_pc=32'h0, out_inst=NOP_INST.
REQ-030 SHALL give rst priority over flush, push and pop in the same cycle; entry storage contents need not be reset.
REQ-031 SHALL on rst mid-operation discard all buffered entries; first post-reset push appears on out_* one cycle after acceptance.

Verification
REQ-032 Reset then idle -> out_valid=0, in_ready=1, count=0, out_inst=32'h0340_0000, out_pc=0.
REQ-033 Push (1c000000,02800c0c), out_ready=0 -> next cycle out_valid=1, out_pc=1c000000, out_inst=02800c0c, count=1; out_ready=1 -> next cycle count=0.
REQ-034 DEPTH=2, push 1c000000, 1c000004, 1c000008 back-to-back with out_ready=0 -> in_ready=0 after second push, third pair held by source; out_ready=1 at full -> in_ready=1 next cycle; outputs ordered 1c000000, 1c000004, 1c000008.
REQ-035 Continuous push+pop for 10 cycles, pc 1c000000 step 4 -> count steady at 1, pointers wrap, every pc seen exactly once in order.
REQ-036 count=2, flush=1 with in_valid=1 (pc 1c000010) and out_ready=1 -> next cycle count=0, out_valid=0; following push of 1c000100 is the next output.
REQ-037 count=2, rst=1 together with flush=1 and in_valid=1 -> next cycle count=0, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//   Small in-order FIFO decoupling instruction fetch from decode. Holds up to
//   DEPTH {pc, inst} pairs. Handshake flags are derived only from the
//   registered occupancy count, so there is no combinational path from
//   out_ready to in_ready and no same-cycle bypass from in_* to out_*.
//
// Parameters
//   DEPTH     entry count; only 2 or 4 are legal (power of two, so the
//             pointers wrap modulo DEPTH by plain overflow)
//   NOP_INST  instruction word presented on out_inst while empty
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_pc/in_inst/in_ready     fetch side handshake
//   flush               branch redirect: drop buffered and incoming pairs
//   out_valid/out_pc/out_inst/out_ready decode side handshake
//   count               number of occupied entries
// ---------------------------------------------------------------------------
module if_id_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;

    // Flags come from the registered count only.
    assign in_ready  = (cnt < CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign count     = cnt;

    // Flush swallows both handshakes in the cycle it is asserted.
    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    assign out_pc   = out_valid ? mem[rd_ptr].pc   : 32'h0;
    assign out_inst = out_valid ? mem[rd_ptr].inst : NOP_INST;

    // Storage has no reset; stale contents are masked by count/out_valid.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_buffer
//   Directed bench for if_id_buffer (DEPTH=2). A queue models the buffer
//   contents: pairs are pushed when the model says the handshake fires and
//   popped/compared when decode consumes. After every cycle the visible
//   state (count, flags, head pc/inst) is compared against the model.
// ---------------------------------------------------------------------------
module tb_if_id_buffer;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0340_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [$clog2(DEPTH):0] count;

    pair_t q[$];
    int    tests = 0;
    int    fails = 0;

    if_id_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [31:0] epc;
        logic [31:0] einst;
        epc   = (q.size() != 0) ? q[0].pc   : 32'h0;
        einst = (q.size() != 0) ? q[0].inst : NOP;
        chk({tag, " count"},     32'(count),     32'(q.size()));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, " in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
        chk({tag, " out_pc"},    out_pc,   epc);
        chk({tag, " out_inst"},  out_inst, einst);
    endtask

    // One clock: decide handshakes from the model, compare consumed data,
    // advance the model at the edge, then check visible state.
    task automatic tick(input string tag);
        bit    do_push;
        bit    do_pop;
        pair_t p;
        #1;
        do_push = in_valid && (q.size() < DEPTH) && !flush;
        do_pop  = (q.size() != 0) && out_ready && !flush;
        if (!rst && do_pop) begin
            chk({tag, " pop pc"},   out_pc,   q[0].pc);
            chk({tag, " pop inst"}, out_inst, q[0].inst);
        end
        p = '{pc: in_pc, inst: in_inst};
        @(posedge clk);
        if (rst || flush) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(p);
        end
        #1;
        check_state(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = 32'h0280_0000 ^ {pc[15:0], pc[31:16]};
        out_ready = rdy;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        tick("reset");
        tick("reset2");
        rst = 1'b0;
        tick("idle");

        // single push then pop
        in_valid = 1'b1; in_pc = 32'h1c00_0000; in_inst = 32'h0280_0c0c; out_ready = 1'b0;
        tick("push1");
        drive(1'b0, 32'h0, 1'b1);
        tick("pop1");
        tick("empty_pop_ignored");

        // fill to full, third pair held off, then drain in order
        drive(1'b1, 32'h1c00_0000, 1'b0); tick("fill_a");
        drive(1'b1, 32'h1c00_0004, 1'b0); tick("fill_b");
        drive(1'b1, 32'h1c00_0008, 1'b0); tick("full_hold");
        drive(1'b1, 32'h1c00_0008, 1'b1); tick("full_pop");
        drive(1'b1, 32'h1c00_0008, 1'b1); tick("push_pop");
        drive(1'b0, 32'h0, 1'b1);         tick("drain1");
        tick("drain2");

        // continuous streaming, count steady at 1
        drive(1'b1, 32'h1c00_0000, 1'b1); tick("stream_prime");
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'h1c00_0000 + 32'(4 * i), 1'b1);
            tick("stream");
        end
        drive(1'b0, 32'h0, 1'b1); tick("stream_drain");

        // flush while full with incoming pair and out_ready
        drive(1'b1, 32'h1c00_0020, 1'b0); tick("pre_flush_a");
        drive(1'b1, 32'h1c00_0024, 1'b0); tick("pre_flush_b");
        drive(1'b1, 32'h1c00_0010, 1'b1); flush = 1'b1; tick("flush");
        flush = 1'b0;
        drive(1'b1, 32'h1c00_0100, 1'b0); tick("post_flush_push");
        drive(1'b0, 32'h0, 1'b1);         tick("post_flush_pop");

        // reset mid-operation beats flush and push
        drive(1'b1, 32'h1c00_0200, 1'b0); tick("pre_rst_a");
        drive(1'b1, 32'h1c00_0204, 1'b0); tick("pre_rst_b");
        drive(1'b1, 32'h1c00_0208, 1'b1); flush = 1'b1; rst = 1'b1; tick("rst_flush");
        rst = 1'b0; flush = 1'b0;
        drive(1'b1, 32'h1c00_0300, 1'b0); tick("post_rst_push");
        drive(1'b0, 32'h0, 1'b1);         tick("post_rst_pop");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
